dp_sync_ram: RTL
================

Name: dp_sync_ram

Overview:
- Parametrised simple-dual-port synchronous RAM; successor to the single-port tristate memory.
- Provides separate write and read ports, per-byte write enables and selectable read latency.
- Defines read-during-write behaviour and reports out-of-range addresses.
- Contains a clear engine that fills the array with INIT_VALUE after reset or on request.
- Used as a generic buffer/register-file store behind bus slaves and FIFOs.

Parameters:
- ADDR_WIDTH, 8, address bits on both ports.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH, 256, number of words; 2 <= DEPTH <= 2**ADDR_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2. Value 2 adds an output register.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (write-through).
- INIT_VALUE, 0, word written to every location by the clear engine.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  single-cycle pulse; starts a clear sweep.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid in the same cycle.
- busy  out  1  clear sweep in progress; accesses are ignored.
- addr_err  out  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (async assert, sync release)
  - rd_data=0, rd_valid=0, addr_err=0, busy=1, FSM=CLEAR, clear counter=0.
  - Array contents are not reset directly; they are overwritten by the sweep.
- FSM state CLEAR
  - Each cycle writes INIT_VALUE to mem[cnt] (all bytes), then cnt++.
  - When cnt==DEPTH-1 is written, transition to IDLE; busy deasserts on the next cycle.
  - A sweep takes exactly DEPTH cycles.
  - wr_en, rd_en and clr are ignored while busy=1: no write, no rd_valid, no addr_err, rd_data holds its value.
- FSM state IDLE
  - clr=1 -> CLEAR with cnt=0; busy=1 from the next cycle.
  - An access presented in the same cycle as clr is still serviced.
- Reset asserted mid-sweep restarts the sweep at address 0.
- Write
  - wr_en=1 and wr_addr<DEPTH: on the clock edge, bytes with wr_be[i]=1 are updated; the others keep their value.
  - wr_be=0 is a legal no-op.
- Read
  - rd_en=1 and rd_addr<DEPTH: rd_data and rd_valid appear RD_LATENCY cycles after the request edge.
  - Back-to-back reads are supported, one per cycle, fully pipelined.
  - rd_data holds its last value when rd_valid=0.
- Out of range (addr>=DEPTH)
  - Write is dropped.
  - Read still produces rd_valid at the normal latency, with rd_data=0.
  - addr_err pulses one cycle after the request edge; a read and a write both out of range give a single pulse.
- Read-during-write, same address, same cycle
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns the pre-write word merged with the enabled bytes of wr_data.
  - Different addresses: fully independent.
- Only RD_LATENCY values 1 and 2 are legal; any other value fails an elaboration-time check.

Test Plan:
- Release reset, hold rd_en=0 -> busy=1 for exactly 256 cycles, then 0. Read addresses 0, 128, 255 -> 0x00000000 each, rd_valid 1 cycle after rd_en (RD_LATENCY=1).
- Write 0xDEADBEEF to 0x10 with be=0xF, then 0x000000AA with be=0x1 -> read 0x10 returns 0xDEADBEAA. Repeat with RD_LATENCY=2 -> rd_valid 2 cycles after rd_en.
- Same cycle: write 0x11223344 to 0x20 (old 0xCAFEF00D) and read 0x20 -> RDW_MODE=0 returns 0xCAFEF00D; RDW_MODE=1 returns 0x11223344. With be=0x3, mode 1 returns 0xCAFE3344.
- DEPTH=200: write to 0xC8, then read 0xC8 -> write dropped, addr_err pulses once per access, rd_valid=1 with rd_data=0. A read of 0xC7 is unaffected.
- Write 0x55 to address 5, pulse clr, then issue writes and reads during busy -> no rd_valid, no addr_err, rd_data unchanged. After 256 cycles address 5 reads INIT_VALUE.
- Assert rst_n=0 at sweep cycle 100 for 3 cycles -> outputs are at reset values immediately. After release, busy=1 for a full 256 cycles.

Source files
------------

// File: rtl/dp_sync_ram.sv
// dp_sync_ram: simple-dual-port synchronous RAM with per-byte write enables,
// selectable read latency (1 or 2), defined read-during-write behaviour,
// out-of-range access reporting and a clear engine that fills the array
// with INIT_VALUE after reset or on request.
module dp_sync_ram #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter int                    RD_LATENCY = 1,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      busy,
    output logic                      addr_err
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = (ADDR_WIDTH)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = (ADDR_WIDTH)'(1);

    // Parameter sanity checks, evaluated while elaborating.
    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("dp_sync_ram: RD_LATENCY must be 1 or 2");
        end
        if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
            $error("dp_sync_ram: DATA_WIDTH must be a positive multiple of 8");
        end
        if (DEPTH < 2 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
            $error("dp_sync_ram: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH");
        end
        if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
            $error("dp_sync_ram: RDW_MODE must be 0 or 1");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    accept;
    logic                    wr_do;
    logic                    rd_do;
    logic                    err_now;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;

    // Accesses are only honoured outside a clear sweep; the state register
    // is the single source of truth for that.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign accept      = (state == ST_IDLE);
    assign wr_do       = accept && wr_en && wr_in_range;
    assign rd_do       = accept && rd_en;
    assign err_now     = accept && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range));

    // Clear-sweep FSM: walks clr_cnt over every word, then idles until clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_ONE;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    // Array write port: the sweep owns the port while clearing, otherwise
    // in-range writes update only the byte lanes that are enabled.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= INIT_VALUE;
        end else if (wr_do) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read word selection: zero for out-of-range, old array contents, and
    // in write-through mode the enabled bytes of a same-address write.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (RDW_MODE == 1 && wr_do && (wr_addr == rd_addr)) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_be[b]) begin
                        rd_word[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // First read stage; data only moves on an accepted read so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_do;
            if (rd_do) begin
                s1_data <= rd_word;
            end
        end
    end

    // Out-of-range flag: one pulse per offending cycle, read and write combined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= err_now;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_out_reg
            logic                  out_valid;
            logic [DATA_WIDTH-1:0] out_data;

            // Optional output register adding the second cycle of latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out_data <= s1_data;
                    end
                end
            end

            assign rd_valid = out_valid;
            assign rd_data  = out_data;
        end else begin : g_no_out_reg
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule
